// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encodings and fetch constants.
package fetch_pkg;

    typedef enum logic {
        FQ_HOLD = 1'b0,
        FQ_RUN  = 1'b1
    } fq_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int          PC_INC    = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; push is accepted while full when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !(rst || clear)) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with in-order return queue and redirect flush.
// Optional macro FETCH_BYPASS_EN: zero-cycle forwarding of a return into an empty queue.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int OPD_WIDTH = 32,
    parameter int PC_WIDTH  = 12,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 mem_req,
    output logic [PC_WIDTH-1:0]  mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [OPD_WIDTH-1:0] mem_rdata,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [OPD_WIDTH-1:0] instr_out,
    output logic [OPD_WIDTH-1:0] instr_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = OPD_WIDTH + PC_WIDTH;

    fq_state_e           state, state_nxt;
    logic [PC_WIDTH-1:0] fetch_pc, tag_head;
    logic [CW-1:0]       outstanding, discard, q_count;
    logic [QW-1:0]       q_head;
    logic                q_empty;
    logic                run, redir, grant, rv, rv_keep, byp, q_push, q_pop;
    logic                q_full_unused, t_full_unused, t_empty_unused;
    logic [CW-1:0]       t_count_unused;
    logic                redirect_pc_unused;

    assign redirect_pc_unused = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= FQ_HOLD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == FQ_HOLD) state_nxt = FQ_RUN;
    end

    assign run     = (state == FQ_RUN);
    assign redir   = run & redirect;
    // Credits cover queued plus in-flight entries so every kept return has a slot.
    assign mem_req = run & ~redirect &
                     (({1'b0, q_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
    assign mem_addr = fetch_pc;
    assign grant    = mem_req & mem_gnt;
    assign rv       = mem_rvalid & (outstanding != '0);
    assign rv_keep  = rv & (discard == '0) & ~redirect;

`ifdef FETCH_BYPASS_EN
    assign byp = rv_keep & q_empty;
`else
    assign byp = 1'b0;
`endif

    assign q_push = rv_keep & ~(byp & instr_ready);
    assign q_pop  = ~q_empty & instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(rv);
            if (redir) begin
                fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
                discard  <= outstanding + CW'(grant) - CW'(rv);
            end else begin
                if (grant)                  fetch_pc <= fetch_pc + PC_WIDTH'(PC_INC);
                if (rv && discard != '0)    discard  <= discard - 1'b1;
            end
        end
    end

    fetch_fifo #(.WIDTH(PC_WIDTH), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redir),
        .push  (grant),
        .din   (fetch_pc),
        .pop   (rv_keep),
        .dout  (tag_head),
        .full  (t_full_unused),
        .empty (t_empty_unused),
        .count (t_count_unused)
    );

    fetch_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redir),
        .push  (q_push),
        .din   ({mem_rdata, tag_head}),
        .pop   (q_pop),
        .dout  (q_head),
        .full  (q_full_unused),
        .empty (q_empty),
        .count (q_count)
    );

    assign instr_valid = ~q_empty | byp;

    always_comb begin
        instr_out = '0;
        instr_pc  = '0;
        if (!q_empty) begin
            instr_out = q_head[QW-1 -: OPD_WIDTH];
            instr_pc  = OPD_WIDTH'(q_head[PC_WIDTH-1:0]);
        end else if (byp) begin
            instr_out = mem_rdata;
            instr_pc  = OPD_WIDTH'(tag_head);
        end
    end

    a_rvalid_credit: assert property (@(posedge clk) disable iff (rst)
        !(mem_rvalid && outstanding == '0));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;
    localparam int OW = 32;
    localparam int PW = 12;
    localparam int D  = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1, redirect = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0, instr_ready = 1'b0;
    logic [PW-1:0] redirect_pc = '0;
    logic [PW-1:0] mem_addr;
    logic [OW-1:0] mem_rdata = '0;
    logic [OW-1:0] instr_out, instr_pc;
    logic          mem_req, instr_valid;

    always #5 clk = ~clk;

    instr_fetch_queue #(.OPD_WIDTH(OW), .PC_WIDTH(PW), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc)
    );

    typedef struct { int unsigned addr; bit disc; } out_t;
    typedef struct { logic [31:0] data; int unsigned pc; } ent_t;

    out_t        outq[$];
    ent_t        dq[$];
    logic [31:0] gaddr[$];
    logic [31:0] acc[$];
    bit          run = 1'b0;
    int unsigned fpc = 0;
    int          n_chk = 0, n_fail = 0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_out, s_pc;

    function automatic logic [31:0] word_at(int unsigned a);
        return 32'hC0DE_0000 | (a & 32'hFFFF);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rd, input logic [PW-1:0] rpc,
                        input bit g, input bit rv, input bit rdy);
        bit          ereq, ebyp, eval;
        logic [31:0] eout, epc;
        out_t        o;
        rst = r; redirect = rd; redirect_pc = rpc; mem_gnt = g; instr_ready = rdy;
        mem_rvalid = rv && !r && outq.size() > 0;
        if (mem_rvalid) mem_rdata = ovr_en ? ovr_data : word_at(outq[0].addr);
        else            mem_rdata = $urandom;
        @(negedge clk);
        ereq = run && !rd && (dq.size() + outq.size() < D);
        ebyp = 1'b0;
        if (BYP && run && mem_rvalid && !rd && dq.size() == 0) ebyp = !outq[0].disc;
        eval = dq.size() > 0 || ebyp;
        eout = '0; epc = '0;
        if (dq.size() > 0) begin eout = dq[0].data; epc = dq[0].pc; end
        else if (ebyp) begin eout = mem_rdata; epc = outq[0].addr; end
        s_req = mem_req; s_valid = instr_valid; s_addr = 32'(mem_addr);
        s_out = instr_out; s_pc = instr_pc;
        chk("mem_req", 32'(s_req), 32'(ereq));
        chk("mem_addr", s_addr, fpc);
        chk("instr_valid", 32'(s_valid), 32'(eval));
        if (eval) begin
            chk("instr_out", s_out, eout);
            chk("instr_pc", s_pc, epc);
        end
        if (s_req && g) gaddr.push_back(s_addr);
        if (s_valid && rdy && !rd && !r) acc.push_back(s_pc);
        if (r) begin
            run = 1'b0; outq.delete(); dq.delete(); fpc = 0;
        end else if (!run) begin
            run = 1'b1;
        end else if (rd) begin
            dq.delete();
            if (mem_rvalid) o = outq.pop_front();
            foreach (outq[i]) outq[i].disc = 1'b1;
            fpc = 32'(rpc) & 32'hFFC;
        end else begin
            if (dq.size() > 0 && rdy) void'(dq.pop_front());
            if (mem_rvalid) begin
                o = outq.pop_front();
                if (!o.disc && !(ebyp && rdy)) dq.push_back('{mem_rdata, o.addr});
            end
            if (ereq && g) begin
                outq.push_back('{fpc, 1'b0});
                fpc = (fpc + 4) % 4096;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, 0, 0);
        step(1, 0, '0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0);
    endtask

    logic v0, v1;
    logic [31:0] o0, o1;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // T1: reset values, first request timing, in-order stream
        repeat (3) step(1, 0, '0, 1, 1, 1);
        chk("rst_req", 32'(s_req), 0);
        chk("rst_valid", 32'(s_valid), 0);
        chk("rst_out", s_out, 0);
        chk("rst_pc", s_pc, 0);
        acc.delete();
        step(0, 0, '0, 1, 1, 1);
        chk("t1_hold_req", 32'(s_req), 0);
        step(0, 0, '0, 1, 1, 1);
        chk("t1_first_req", 32'(s_req), 1);
        chk("t1_first_addr", s_addr, 32'h000);
        repeat (8) step(0, 0, '0, 1, 1, 1);
        chk("t1_pc0", acc[0], 32'h0);
        chk("t1_pc1", acc[1], 32'h4);
        chk("t1_pc2", acc[2], 32'h8);
        chk("t1_pc3", acc[3], 32'hC);

        // T2: credit stall with no returns, then resume
        do_reset();
        gaddr.delete();
        repeat (8) step(0, 0, '0, 1, 0, 0);
        chk("t2_grants", 32'(gaddr.size()), 4);
        chk("t2_stalled", 32'(s_req), 0);
        chk("t2_g3", gaddr[3], 32'h00C);
        repeat (8) step(0, 0, '0, 1, 1, 1);
        chk("t2_resume", gaddr[4], 32'h010);

        // T3: redirect with three in flight
        do_reset();
        repeat (3) step(0, 0, '0, 1, 0, 1);
        acc.delete();
        step(0, 1, 12'h203, 1, 0, 1);
        step(0, 0, '0, 1, 1, 1);
        chk("t3_req", 32'(s_req), 1);
        chk("t3_addr", s_addr, 32'h200);
        repeat (12) step(0, 0, '0, 1, 1, 1);
        chk("t3_pc0", acc[0], 32'h200);
        chk("t3_pc1", acc[1], 32'h204);

        // T4: address wrap
        do_reset();
        step(0, 1, 12'hFFE, 0, 0, 1);
        acc.delete();
        step(0, 0, '0, 1, 0, 1);
        chk("t4_addr_ffc", s_addr, 32'hFFC);
        step(0, 0, '0, 1, 0, 1);
        chk("t4_addr_wrap", s_addr, 32'h000);
        repeat (6) step(0, 0, '0, 0, 1, 1);
        chk("t4_pc0", acc[0], 32'hFFC);
        chk("t4_pc1", acc[1], 32'h000);

        // T5: simultaneous push and pop near full
        do_reset();
        repeat (4) step(0, 0, '0, 1, 0, 0);
        repeat (3) step(0, 0, '0, 0, 1, 0);
        acc.delete();
        step(0, 0, '0, 0, 1, 1);
        repeat (4) step(0, 0, '0, 0, 0, 1);
        chk("t5_n", 32'(acc.size()), 4);
        chk("t5_pc0", acc[0], 32'h0);
        chk("t5_pc3", acc[3], 32'hC);

        // T6: bypass latency
        do_reset();
        step(0, 0, '0, 1, 0, 1);
        step(0, 0, '0, 0, 0, 1);
        ovr_en = 1'b1; ovr_data = 32'h00A0_0093;
        step(0, 0, '0, 0, 1, 1);
        v0 = s_valid; o0 = s_out;
        ovr_en = 1'b0;
        step(0, 0, '0, 0, 0, 1);
        v1 = s_valid; o1 = s_out;
        chk("t6_same_valid", 32'(v0), 32'(BYP));
        chk("t6_next_valid", 32'(v1), 32'(!BYP));
        chk("t6_data", BYP ? o0 : o1, 32'h00A0_0093);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 31) == 0,
                 PW'($urandom_range(0, 4095)),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
